// File: rtl/rx_block_packer.sv
// Receive-path word packer: collects WORDS_PER_BLOCK FIFO words per MCU strobe into one
// cipher block and holds it for the cipher core, flagging busy/overrun back to the MCU.
module rx_block_packer #(
  parameter int WORD_W          = 8,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                                   clk,
  input  logic                                   n_reset,
  input  logic                                   clear,
  input  logic                                   read_fifo,
  input  logic [WORD_W-1:0]                      rx_data,
  input  logic                                   is_encrypt,
  input  logic                                   cipher_ready,
  output logic                                   block_valid,
  output logic [WORD_W*WORDS_PER_BLOCK-1:0]      block_data,
  output logic                                   block_is_encrypt,
  output logic                                   accepted,
  output logic [$clog2(WORDS_PER_BLOCK+1)-1:0]   fill_level,
  output logic                                   overrun,
  output logic                                   dbg_state
);

  localparam int BLOCK_W = WORD_W * WORDS_PER_BLOCK;
  localparam int FILL_W  = $clog2(WORDS_PER_BLOCK + 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [BLOCK_W-1:0]  data_q, data_d;
  logic                enc_q, enc_d;
  logic                overrun_q, overrun_d;

  // Handshake: a block transfers on any cycle where block_valid and cipher_ready are both
  // high; once block_valid rises, block_data and block_is_encrypt stay fixed until that
  // transfer (or clear), and cipher_ready has no effect while block_valid is low.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    data_d    = data_q;
    enc_d     = enc_q;
    overrun_d = overrun_q;
    if (clear) begin
      state_d   = FILL;
      fill_d    = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (read_fifo) begin
            for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
              if (fill_q == FILL_W'(k)) data_d[BLOCK_W-1-k*WORD_W -: WORD_W] = rx_data;
            end
            if (fill_q == '0) enc_d = is_encrypt;
            fill_d = fill_q + FILL_W'(1);
            if (fill_q == FILL_W'(WORDS_PER_BLOCK - 1)) state_d = FULL;
          end
        end
        FULL: begin
          // Strobes while busy are dropped, including on the handshake cycle.
          if (read_fifo) overrun_d = 1'b1;
          if (cipher_ready) begin
            state_d = FILL;
            fill_d  = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= FILL;
      fill_q    <= '0;
      data_q    <= '0;
      enc_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      data_q    <= data_d;
      enc_q     <= enc_d;
      overrun_q <= overrun_d;
    end
  end

  assign block_valid      = (state_q == FULL);
  assign accepted         = (state_q == FULL);
  assign block_data       = data_q;
  assign block_is_encrypt = enc_q;
  assign fill_level       = fill_q;
  assign overrun          = overrun_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_rx_block_packer.sv
// Bench for rx_block_packer: directed scenarios plus random traffic against a word-list
// model; completed blocks go to an expected queue that a negedge monitor drains.
module tb_rx_block_packer;

  localparam int WW  = 8;
  localparam int WPB = 8;
  localparam int BW  = WW * WPB;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          clear;
  logic          read_fifo;
  logic [WW-1:0] rx_data;
  logic          is_encrypt;
  logic          cipher_ready;
  logic          block_valid;
  logic [BW-1:0] block_data;
  logic          block_is_encrypt;
  logic          accepted;
  logic [3:0]    fill_level;
  logic          overrun;
  logic          dbg_state;

  rx_block_packer #(.WORD_W(WW), .WORDS_PER_BLOCK(WPB)) dut (
    .clk              (clk),
    .n_reset          (n_reset),
    .clear            (clear),
    .read_fifo        (read_fifo),
    .rx_data          (rx_data),
    .is_encrypt       (is_encrypt),
    .cipher_ready     (cipher_ready),
    .block_valid      (block_valid),
    .block_data       (block_data),
    .block_is_encrypt (block_is_encrypt),
    .accepted         (accepted),
    .fill_level       (fill_level),
    .overrun          (overrun),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [BW:0]   exp_q[$];     // {is_encrypt, block}
  logic [WW-1:0] m_words[$];
  logic          m_full = 1'b0;
  logic          m_enc  = 1'b0;
  logic          m_ovr  = 1'b0;
  int            m_fill = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_words.delete();
    exp_q.delete();
    m_full = 1'b0;
    m_ovr  = 1'b0;
    m_fill = 0;
  endtask

  task automatic model_edge(input logic rd, input logic [WW-1:0] d, input logic enc,
                            input logic rdy, input logic clr);
    logic [BW-1:0] blk;
    if (clr) begin
      if (m_full && exp_q.size() > 0) void'(exp_q.pop_back());
      m_words.delete();
      m_full = 1'b0;
      m_ovr  = 1'b0;
    end else if (m_full) begin
      if (rd)  m_ovr  = 1'b1;
      if (rdy) m_full = 1'b0;
    end else if (rd) begin
      if (m_words.size() == 0) m_enc = enc;
      m_words.push_back(d);
      if (m_words.size() == WPB) begin
        blk = '0;
        foreach (m_words[i]) blk = {blk[BW-WW-1:0], m_words[i]};
        exp_q.push_back({m_enc, blk});
        m_words.delete();
        m_full = 1'b1;
      end
    end
    m_fill = m_full ? WPB : m_words.size();
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rd, input logic [WW-1:0] d, input logic enc,
                      input logic rdy, input logic clr);
    read_fifo    = rd;
    rx_data      = d;
    is_encrypt   = enc;
    cipher_ready = rdy;
    clear        = clr;
    @(posedge clk);
    model_edge(rd, d, enc, rdy, clr);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic handshake();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"},    BW'(block_valid),      '0);
    chk({tag, "_accepted"}, BW'(accepted),         '0);
    chk({tag, "_fill"},     BW'(fill_level),       '0);
    chk({tag, "_overrun"},  BW'(overrun),          '0);
    chk({tag, "_data"},     block_data,            '0);
    chk({tag, "_enc"},      BW'(block_is_encrypt), '0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (n_reset === 1'b1) begin
      chk("mon_valid",    BW'(block_valid), BW'(m_full));
      chk("mon_accepted", BW'(accepted),    BW'(m_full));
      chk("mon_state",    BW'(dbg_state),   BW'(m_full));
      chk("mon_fill",     BW'(fill_level),  BW'(m_fill));
      chk("mon_overrun",  BW'(overrun),     BW'(m_ovr));
      if (block_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_block: got %h expected none at %0t", block_data, $time);
        end else begin
          chk("sb_block_data", block_data,            exp_q[0][BW-1:0]);
          chk("sb_block_enc",  BW'(block_is_encrypt), BW'(exp_q[0][BW]));
          if (cipher_ready && !clear) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_reset      = 1'b0;
    clear        = 1'b0;
    read_fifo    = 1'b0;
    rx_data      = '0;
    is_encrypt   = 1'b0;
    cipher_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    n_reset = 1'b1;
    idle();

    // Fill one encrypt block, hold it with cipher_ready low.
    for (int i = 1; i <= 8; i++) step(1'b1, WW'(i * 8'h11), 1'b1, 1'b0, 1'b0);
    chk("t1_valid", BW'(block_valid), BW'(1));
    chk("t1_accepted", BW'(accepted), BW'(1));
    chk("t1_data", block_data, 64'h1122334455667788);
    chk("t1_enc", BW'(block_is_encrypt), BW'(1));
    chk("t1_fill", BW'(fill_level), BW'(8));
    idle();

    // Strobe while busy, then again on the handshake cycle.
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("t3_overrun", BW'(overrun), BW'(1));
    chk("t3_data_held", block_data, 64'h1122334455667788);
    step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    chk("t2_valid_low", BW'(block_valid), '0);
    chk("t2_accepted_low", BW'(accepted), '0);
    chk("t2_fill_zero", BW'(fill_level), '0);
    chk("t3_data_kept", block_data, 64'h1122334455667788);

    // Decrypt block.
    for (int i = 0; i < 8; i++) step(1'b1, WW'(8'h21 + i), 1'b0, 1'b0, 1'b0);
    chk("t2_enc", BW'(block_is_encrypt), '0);
    chk("t2_data", block_data, 64'h2122232425262728);
    handshake();

    // Clear mid-block, then a clean block.
    for (int i = 0; i < 5; i++) step(1'b1, 8'hE0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    chk("t4_fill", BW'(fill_level), '0);
    chk("t4_overrun", BW'(overrun), '0);
    for (int i = 1; i <= 8; i++) step(1'b1, WW'(i), 1'b0, 1'b0, 1'b0);
    chk("t4_data", block_data, 64'h0102030405060708);
    handshake();

    // Mode toggles after first word.
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    chk("t5_enc", BW'(block_is_encrypt), BW'(1));
    handshake();

    // Async reset mid-block.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    n_reset = 1'b0;
    #1;
    check_all_zero("t6_async");
    model_reset();
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, WW'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    chk("t6_data", block_data, 64'hC0C1C2C3C4C5C6C7);
    handshake();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, WW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);
    end

    // Drain.
    repeat (3) handshake();
    chk("drain_empty", BW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
